// File: rtl/pisca_leds_multi_if.sv
// Configuration write port for pisca_leds_multi.
// The master drives a one-cycle write. The slave (the LED driver) samples it on the clock edge.
interface pisca_leds_multi_if #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 10
);
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic             wr_en;
  logic [CH_W-1:0]  wr_ch;
  logic [1:0]       wr_mode;
  logic [CNT_W-1:0] wr_value;

  modport master (output wr_en, wr_ch, wr_mode, wr_value);
  modport slave  (input  wr_en, wr_ch, wr_mode, wr_value);
endinterface

// File: rtl/pisca_leds_multi.sv
// pisca_leds_multi: CHANNELS independent LED outputs that share one prescaled tick.
// Each channel has its own mode and value, set through the write port.
//
// Optional feature macro: PISCA_PWM_EN.
//   Defined   -> mode 11 is PWM, and a duty comparator is built for each channel.
//   Undefined -> mode 11 behaves exactly like BLINK, and no comparator is built.
//
// mode | meaning
// 00   | OFF   : led 0, cnt holds
// 01   | ON    : led 1, cnt holds
// 10   | BLINK : toggle led every (value+1) ticks
// 11   | PWM   : led = (cnt < value), cnt free-runs on ticks
module pisca_leds_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 10,
  parameter int PRESC    = 1024
) (
  input  logic                 clk_in1,
  input  logic                 rst_n,
  pisca_leds_multi_if.slave    wr_if,
  output logic [CHANNELS-1:0]  led_out1,
  output logic                 tick_out
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'b00,
    MODE_ON    = 2'b01,
    MODE_BLINK = 2'b10,
    MODE_PWM   = 2'b11
  } mode_t;

  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PRESC_LAST);

  // Shared prescaler. The tick is internal; tick_out is that tick delayed by one clock.
  always_ff @(posedge clk_in1 or negedge rst_n) begin
    if (!rst_n) begin
      r_presc  <= '0;
      tick_out <= 1'b0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + PW'(1);
      tick_out <= w_tick;
    end
  end

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    mode_t            r_mode,  w_mode_nxt;
    logic [CNT_W-1:0] r_value, w_value_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic             r_led,   w_led_nxt;
    logic             w_hit;

    // A channel index at or above CHANNELS matches no channel, so that write is dropped.
    assign w_hit = wr_if.wr_en && (wr_if.wr_ch == CH_W'(g));

    // Next-state logic for the channel. A write has priority over a tick on the same edge.
    always_comb begin
      w_mode_nxt  = r_mode;
      w_value_nxt = r_value;
      w_cnt_nxt   = r_cnt;
      w_led_nxt   = r_led;
      if (w_hit) begin
        w_mode_nxt  = mode_t'(wr_if.wr_mode);
        w_value_nxt = wr_if.wr_value;
        w_cnt_nxt   = '0;
        w_led_nxt   = (wr_if.wr_mode == MODE_ON);
      end else begin
        case (r_mode)
          MODE_OFF: w_led_nxt = 1'b0;
          MODE_ON:  w_led_nxt = 1'b1;
`ifdef PISCA_PWM_EN
          MODE_PWM: begin
            if (w_tick) w_cnt_nxt = r_cnt + CNT_W'(1);
            // Compare against the current cnt, so led lags the cnt update by one clock.
            w_led_nxt = (r_cnt < r_value);
          end
`endif
          default: begin
            // BLINK. Without PISCA_PWM_EN, mode 11 also takes this branch.
            if (w_tick) begin
              if (r_cnt == r_value) begin
                w_cnt_nxt = '0;
                w_led_nxt = ~r_led;
              end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
              end
            end
          end
        endcase
      end
    end

    // Channel state registers.
    always_ff @(posedge clk_in1 or negedge rst_n) begin
      if (!rst_n) begin
        r_mode  <= MODE_OFF;
        r_value <= '0;
        r_cnt   <= '0;
        r_led   <= 1'b0;
      end else begin
        r_mode  <= w_mode_nxt;
        r_value <= w_value_nxt;
        r_cnt   <= w_cnt_nxt;
        r_led   <= w_led_nxt;
      end
    end

    assign led_out1[g] = r_led;
  end

endmodule

// File: tb/tb_pisca_leds_multi.sv
// Scoreboard bench for pisca_leds_multi, with CHANNELS=3, CNT_W=4 and PRESC=4.
// On every clock edge, a reference model pushes the expected {tick_out, led_out1} into a queue.
// The model counts ticks since each channel's last write and derives the LED level arithmetically.
// A monitor pops the queue on the falling edge and compares.
module tb_pisca_leds_multi;
  localparam int CH = 3;
  localparam int W  = 4;
  localparam int P  = 4;

  logic          clk_in1 = 1'b0;
  logic          rst_n   = 1'b0;
  logic [CH-1:0] led_out1;
  logic          tick_out;

  pisca_leds_multi_if #(.CHANNELS(CH), .CNT_W(W)) wr_if ();

  pisca_leds_multi #(.CHANNELS(CH), .CNT_W(W), .PRESC(P)) dut (
    .clk_in1  (clk_in1),
    .rst_n    (rst_n),
    .wr_if    (wr_if),
    .led_out1 (led_out1),
    .tick_out (tick_out)
  );

  always #5 clk_in1 = ~clk_in1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  // n   : edges since reset release
  // m_k : ticks seen since the channel's last write
  int n;
  int m_mode [CH];
  int m_val  [CH];
  int m_k    [CH];
  logic [CH:0] exp_q [$];

  always @(posedge clk_in1) begin : model
    logic [CH-1:0] led;
    logic          tk;
    int            kprev;
    int            em;
    if (!rst_n) begin
      n = 0;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_val[c] = 0; m_k[c] = 0;
      end
      exp_q.push_back('0);
    end else begin
      n  = n + 1;
      tk = ((n % P) == 0);
      led = '0;
      for (int c = 0; c < CH; c++) begin
        if (wr_if.wr_en && (wr_if.wr_ch == c)) begin
          m_mode[c] = wr_if.wr_mode;
          m_val[c]  = wr_if.wr_value;
          m_k[c]    = 0;
          led[c]    = (m_mode[c] == 1);
        end else begin
          kprev = m_k[c];
          if (tk) m_k[c] = m_k[c] + 1;
          em = m_mode[c];
`ifndef PISCA_PWM_EN
          if (em == 3) em = 2;
`endif
          case (em)
            0:       led[c] = 1'b0;
            1:       led[c] = 1'b1;
            2:       led[c] = (((m_k[c] / (m_val[c] + 1)) % 2) == 1);
            default: led[c] = ((kprev % (1 << W)) < m_val[c]);
          endcase
        end
      end
      exp_q.push_back({tk, led});
    end
  end

  always @(negedge clk_in1) begin : monitor
    logic [CH:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if ({tick_out, led_out1} !== e) begin
        n_bad++;
        $display("FAIL scoreboard t=%0t: got led=%b tick=%b, expected led=%b tick=%b",
                 $time, led_out1, tick_out, e[CH-1:0], e[CH]);
      end
    end
  end

  task automatic wr(input int ch, input int md, input int v);
    wr_if.wr_en    = 1'b1;
    wr_if.wr_ch    = 2'(ch);
    wr_if.wr_mode  = 2'(md);
    wr_if.wr_value = 4'(v);
    @(posedge clk_in1); #1;
    wr_if.wr_en    = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) @(posedge clk_in1);
    #1;
  endtask

  initial begin
    int guard;
    wr_if.wr_en = 1'b0; wr_if.wr_ch = '0; wr_if.wr_mode = '0; wr_if.wr_value = '0;
    repeat (3) @(posedge clk_in1);
    #1 rst_n = 1'b1;
    idle(12);

    // Put all channels ON, then assert reset between clock edges.
    wr(0, 1, 0); wr(1, 1, 0); wr(2, 1, 0);
    idle(2);
    @(negedge clk_in1); #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (led_out1 !== 3'b000 || tick_out !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got led=%b tick=%b, expected led=000 tick=0", led_out1, tick_out);
    end
    repeat (2) @(posedge clk_in1);
    #1 rst_n = 1'b1;
    idle(10);

    // BLINK with V=2 on ch0.
    wr(0, 2, 2); idle(60);
    // PWM with D=4, then D=0, on ch1. Without PISCA_PWM_EN, mode 11 behaves as BLINK.
    wr(1, 3, 4); idle(140);
    wr(1, 3, 0); idle(70);
    // ON, OFF and an out-of-range channel.
    wr(2, 1, 0); idle(3);
    wr(2, 0, 0); idle(3);
    wr(3, 1, 7); idle(5);

    // Write that lands on an edge where the tick is asserted.
    guard = 0;
    while ((((n + 1) % P) != 0) && guard < 2 * P) begin
      idle(1);
      guard++;
    end
    wr(0, 2, 1); idle(30);

    // Mode 11 with V=2 on ch1.
    wr(1, 3, 2); idle(60);

    // Random writes, including out-of-range channels.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0)
        wr($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15));
      idle($urandom_range(1, 30));
    end
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pisca_leds_multi.md
# pisca_leds_multi

Parametrised multi-channel LED driver. It generalises the single free-running blinker into CHANNELS independent outputs, each with its own mode (off, on, blink, PWM) and 10-bit-class rate/duty value, all sharing one prescaled tick. A simple one-cycle write port sets each channel's configuration. It sits between the board-level LED pins and any controller or test logic that selects blink patterns.

## Interface
- CHANNELS, 4: number of LED outputs, from 1 to 16.
- CNT_W, 10: width of each channel counter and value field.
- PRESC, 1024: clocks per tick, at least 1. PRESC=1 gives a tick every clock.
- clk_in1  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- wr_en  input  1  configuration write strobe, sampled on the clock edge.
- wr_ch  input  max(1,$clog2(CHANNELS))  channel index for the write.
- wr_mode  input  2  mode to write: 00 OFF, 01 ON, 10 BLINK, 11 PWM.
- wr_value  input  CNT_W  BLINK half-period value, or PWM duty.
- led_out1  output  CHANNELS  registered LED drive, bit i is channel i.
- tick_out  output  1  registered one-clock pulse on each prescaler wrap.

## Operation
- Reset (rst_n=0, asynchronous):
  - prescaler = 0 and tick_out = 0
  - every channel: mode = OFF, value = 0, cnt = 0
  - led_out1 = 0
- Prescaler:
  - counts 0..PRESC-1 and then wraps to 0.
  - tick_out = 1 for the one clock after the edge on which the count wraps.
  - Internal tick is asserted whenever the count equals PRESC-1.
- Write: on an edge with wr_en=1 and wr_ch < CHANNELS:
  - mode and value of that channel are updated.
  - Its cnt = 0 and its led_out1 bit = 0, except in mode ON, where the bit is 1.
  - Writes with wr_ch >= CHANNELS are ignored.
  - Writes never disturb the prescaler or other channels.
- OFF: led bit = 0, and cnt holds.
- ON: led bit = 1, and cnt holds.
- BLINK with value V, on each tick:
  - If cnt == V: cnt = 0 and the led bit toggles.
  - Otherwise: cnt = cnt + 1.
  - Half-period = (V+1) ticks, so the full period = 2(V+1)·PRESC clocks.
  - V=0 toggles on every tick.
- PWM with value D, on each tick:
  - cnt = cnt + 1, with natural wrap at 2^CNT_W.
  - Every clock, the led bit is registered as (cnt < D).
  - Duty = D/2^CNT_W. D=0 means always 0. Full-on is not reachable in PWM; use ON instead.
- Arithmetic: all comparisons are unsigned, CNT_W bits wide, with no saturation.
- Simultaneous write and tick on the same channel: the write wins, and the tick has no effect on that channel that cycle.
- A write while a channel is mid-period restarts that channel's phase. The prescaler phase is not reset.

## Timing
- Write-to-output latency is 1 clock: led_out1 reflects the new mode's initial level on the edge after the write.
- BLINK: the toggle appears on led_out1 on the same edge as the tick that matches cnt == V.
- PWM: led_out1 lags the cnt update by 1 clock, because the comparison is registered.
- tick_out lags the internal tick by 1 clock.
- On reset deassertion, the first tick occurs PRESC clocks after the first active edge.

## Configuration
- PISCA_PWM_EN:
  - Defined: mode 11 is PWM as described above, and the per-channel comparators are instantiated.
  - Undefined: mode 11 behaves exactly like BLINK (10) with the same value, and no PWM compare logic is built.

## Test plan
Bench parameters: CHANNELS=3, CNT_W=4, PRESC=4.
- Reset: put all channels in ON, then pull rst_n low between clock edges → led_out1=000 and tick_out=0 immediately, with no clock needed. After release, tick_out pulses every 4 clocks.
- BLINK: write ch0 mode=10, V=2 → led_out1[0] toggles every 12 clocks (period 24, 50% duty). The first toggle comes on the 3rd tick after the write.
- PWM (macro defined): write ch1 mode=11, D=4 → led_out1[1] is high for 16 clocks of every 64. With D=0 it stays low permanently.
- ON/OFF and out-of-range:
  - Write ch2 ON → bit 2 = 1 on the next edge.
  - Write ch2 OFF → bit 2 = 0 on the next edge.
  - Write wr_ch=3 → led_out1 and all configs are unchanged.
- Write colliding with a tick: write ch0 BLINK V=1 on an edge where the tick is asserted → cnt=0 and the bit is 0. The first toggle comes 2 ticks (8 clocks) later.
- Macro undefined: write ch1 mode=11, V=2 → waveform is identical to BLINK V=2, with a period of 24 clocks.
